// File: rtl/sfx_player.sv
// Sound-effect sequencer: steps through music-sheet entries and plays each one as a square wave.
// Optional build macro SFX_RESTART_EN: a start while busy restarts the sequence instead of being ignored.
module sfx_player #(
    parameter int unsigned TICK_CYCLES = 6_250_000,
    parameter int unsigned NOTE_W      = 20,
    parameter int unsigned DUR_W       = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        sound_sel,
    input  logic [NOTE_W-1:0] note,
    input  logic [DUR_W-1:0]  duration,
    input  logic              done,
    output logic [1:0]        sound,
    output logic [1:0]        number,
    output logic              speaker,
    output logic              busy,
    output logic              finished
);

    localparam int unsigned TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
    localparam logic [NOTE_W-2:0] HALF_ONE  = (NOTE_W - 1)'(1);
    localparam logic [DUR_W-1:0]  UNIT_ONE  = DUR_W'(1);

`ifdef SFX_RESTART_EN
    localparam bit RESTART_EN = 1'b1;
`else
    localparam bit RESTART_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        PLAY  = 2'd2
    } state_t;

    state_t            state;
    logic [TICK_W-1:0] tick_cnt;
    logic [NOTE_W-2:0] half;
    logic [NOTE_W-2:0] half_cnt;
    logic [DUR_W-1:0]  units;

    // Index 3 is the last sheet slot: stepping past it ends the sound rather than wrapping.
    logic last_slot;
    assign last_slot = (number == 2'd3);

    // NOTE: every state register uses <= so all updates see the pre-edge values together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sound    <= 2'b11;
            number   <= 2'd0;
            speaker  <= 1'b0;
            busy     <= 1'b0;
            finished <= 1'b0;
            tick_cnt <= '0;
            half     <= '0;
            half_cnt <= '0;
            units    <= '0;
        end else begin
            finished <= 1'b0;
            if (RESTART_EN && start && (state != IDLE)) begin
                sound    <= sound_sel;
                number   <= 2'd0;
                speaker  <= 1'b0;
                tick_cnt <= '0;
                half     <= '0;
                half_cnt <= '0;
                units    <= '0;
                state    <= FETCH;
            end else begin
                case (state)
                    IDLE: begin
                        // The finished pulse cycle still belongs to the old sequence.
                        if (start && !finished) begin
                            sound  <= sound_sel;
                            number <= 2'd0;
                            busy   <= 1'b1;
                            state  <= FETCH;
                        end
                    end

                    FETCH: begin
                        if (done || ((duration == '0) && last_slot)) begin
                            state    <= IDLE;
                            finished <= 1'b1;
                            busy     <= 1'b0;
                            speaker  <= 1'b0;
                            number   <= 2'd0;
                        end else if (duration == '0) begin
                            number <= number + 2'd1;
                        end else begin
                            half     <= note[NOTE_W-1:1];
                            units    <= duration;
                            tick_cnt <= '0;
                            half_cnt <= '0;
                            speaker  <= 1'b0;
                            state    <= PLAY;
                        end
                    end

                    PLAY: begin
                        if (half != '0) begin
                            if (half_cnt == half - HALF_ONE) begin
                                half_cnt <= '0;
                                speaker  <= ~speaker;
                            end else begin
                                half_cnt <= half_cnt + HALF_ONE;
                            end
                        end else begin
                            speaker <= 1'b0;
                        end

                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt <= '0;
                            units    <= units - UNIT_ONE;
                            if (units == UNIT_ONE) begin
                                speaker <= 1'b0;
                                if (last_slot) begin
                                    state    <= IDLE;
                                    finished <= 1'b1;
                                    busy     <= 1'b0;
                                    number   <= 2'd0;
                                end else begin
                                    number <= number + 2'd1;
                                    state  <= FETCH;
                                end
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TICK_ONE;
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
